mii_tx_arbiter: RTL

Arbitrates the 1.6T MII transmit lane (64-bit data / 8-bit control columns) between N_REQ frame sources. It grants sources round-robin and wraps each granted frame with start and terminate control characters. It inserts error columns on source underrun and enforces a programmable minimum inter-packet gap of idle columns. It sits between the per-source frame generators and the MII transmit interface; the MII checker consumes its output.

---
 rtl/mii_tx_arbiter.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/mii_tx_arbiter.sv
// Round-robin arbiter for the 64-bit MII transmit lane: wraps each granted frame in
// START/terminate columns, emits ERROR columns on source underrun and enforces the idle gap.
module mii_tx_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = 8,
    parameter int N_REQ      = 2
) (
    input  logic                        clk,
    input  logic                        i_rst_n,
    input  logic                        i_enable,
    input  logic [3:0]                  i_ipg_cols,
    input  logic [N_REQ-1:0]            i_req_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0] i_req_data,
    input  logic [N_REQ-1:0]            i_req_last,
    input  logic [N_REQ*3-1:0]          i_req_lastb,
    output logic [N_REQ-1:0]            o_req_ready,
    output logic [DATA_WIDTH-1:0]       o_tx_data,
    output logic [CTRL_WIDTH-1:0]       o_tx_ctrl,
    output logic [N_REQ-1:0]            o_grant,
    output logic                        o_busy,
    output logic                        o_underrun
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [DATA_WIDTH-1:0] IDLE_COL  = 64'h0707070707070707;
    localparam logic [DATA_WIDTH-1:0] START_COL = 64'hD5555555555555FB;
    localparam logic [DATA_WIDTH-1:0] ERROR_COL = 64'hFEFEFEFEFEFEFEFE;
    localparam logic [CTRL_WIDTH-1:0] CTRL_ALL  = {CTRL_WIDTH{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_PAYLOAD,
        S_TERM,
        S_IPG
    } state_t;

    state_t                  r_state,     w_stateNext;
    logic [N_REQ-1:0]        r_grant,     w_grantNext;
    logic [IDX_W-1:0]        r_owner,     w_ownerNext;
    logic [IDX_W-1:0]        r_rr,        w_rrNext;
    logic [3:0]              r_cnt,       w_cntNext;
    logic [DATA_WIDTH-1:0]   r_txData,    w_txDataNext;
    logic [CTRL_WIDTH-1:0]   r_txCtrl,    w_txCtrlNext;
    logic                    r_underrun,  w_underrunNext;

    logic                    w_ownValid;
    logic                    w_ownLast;
    logic [2:0]              w_ownLastb;
    logic [DATA_WIDTH-1:0]   w_ownData;
    logic                    w_found;
    logic [IDX_W-1:0]        w_winner;
    logic [3:0]              w_ipgLoad;

    // Lanes below k keep word data, lane k carries the terminate, the rest are idle fill.
    function automatic logic [DATA_WIDTH-1:0] termData(input logic [DATA_WIDTH-1:0] word,
                                                      input logic [2:0] k);
        logic [DATA_WIDTH-1:0] res;
        res = IDLE_COL;
        for (int b = 0; b < CTRL_WIDTH; b++) begin
            if (b < int'(k))
                res[b*8 +: 8] = word[b*8 +: 8];
            else if (b == int'(k))
                res[b*8 +: 8] = 8'hFD;
            else
                res[b*8 +: 8] = 8'h07;
        end
        return res;
    endfunction

    assign w_ipgLoad = (i_ipg_cols == 4'd0) ? 4'd1 : i_ipg_cols;

    always_comb begin
        w_ownValid = 1'b0;
        w_ownLast  = 1'b0;
        w_ownLastb = '0;
        w_ownData  = '0;
        for (int r = 0; r < N_REQ; r++) begin
            if (r_owner == IDX_W'(r)) begin
                w_ownValid = i_req_valid[r];
                w_ownLast  = i_req_last[r];
                w_ownLastb = i_req_lastb[r*3 +: 3];
                w_ownData  = i_req_data[r*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_rr;
        for (int i = 1; i <= N_REQ; i++) begin
            for (int r = 0; r < N_REQ; r++) begin
                if (!w_found && i_req_valid[r] && (((int'(r_rr) + i) % N_REQ) == r)) begin
                    w_found  = 1'b1;
                    w_winner = IDX_W'(r);
                end
            end
        end
    end

    always_comb begin
        w_stateNext    = r_state;
        w_grantNext    = r_grant;
        w_ownerNext    = r_owner;
        w_rrNext       = r_rr;
        w_cntNext      = r_cnt;
        w_txDataNext   = IDLE_COL;
        w_txCtrlNext   = CTRL_ALL;
        w_underrunNext = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_enable && w_found) begin
                    w_stateNext  = S_START;
                    w_ownerNext  = w_winner;
                    w_rrNext     = w_winner;
                    w_txDataNext = START_COL;
                    w_txCtrlNext = CTRL_WIDTH'(1);
                    for (int r = 0; r < N_REQ; r++)
                        w_grantNext[r] = (w_winner == IDX_W'(r));
                end
            end
            S_START, S_PAYLOAD: begin
                if (w_ownValid) begin
                    if (!w_ownLast) begin
                        w_stateNext  = S_PAYLOAD;
                        w_txDataNext = w_ownData;
                        w_txCtrlNext = '0;
                    end else if (w_ownLastb == 3'd7) begin
                        w_stateNext  = S_TERM;
                        w_txDataNext = w_ownData;
                        w_txCtrlNext = '0;
                    end else begin
                        w_stateNext  = S_IPG;
                        w_txDataNext = termData(w_ownData, w_ownLastb + 3'd1);
                        w_txCtrlNext = CTRL_ALL << (w_ownLastb + 3'd1);
                        w_cntNext    = w_ipgLoad;
                        w_grantNext  = '0;
                    end
                end else begin
                    // A missing word does not end the frame; it is marked with an error column.
                    w_stateNext    = S_PAYLOAD;
                    w_txDataNext   = ERROR_COL;
                    w_underrunNext = 1'b1;
                end
            end
            S_TERM: begin
                w_stateNext  = S_IPG;
                w_txDataNext = termData(IDLE_COL, 3'd0);
                w_cntNext    = w_ipgLoad;
                w_grantNext  = '0;
            end
            S_IPG: begin
                if (r_cnt <= 4'd1) begin
                    w_stateNext = S_IDLE;
                    w_cntNext   = '0;
                end else begin
                    w_cntNext = r_cnt - 4'd1;
                end
            end
            default: begin
                w_stateNext = S_IDLE;
                w_grantNext = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_grant    <= '0;
            r_owner    <= '0;
            r_rr       <= IDX_W'(N_REQ - 1);
            r_cnt      <= '0;
            r_txData   <= IDLE_COL;
            r_txCtrl   <= CTRL_ALL;
            r_underrun <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_grant    <= w_grantNext;
            r_owner    <= w_ownerNext;
            r_rr       <= w_rrNext;
            r_cnt      <= w_cntNext;
            r_txData   <= w_txDataNext;
            r_txCtrl   <= w_txCtrlNext;
            r_underrun <= w_underrunNext;
        end
    end

    assign o_req_ready = ((r_state == S_START) || (r_state == S_PAYLOAD)) ? r_grant : '0;
    assign o_tx_data   = r_txData;
    assign o_tx_ctrl   = r_txCtrl;
    assign o_grant     = r_grant;
    assign o_busy      = (r_state != S_IDLE);
    assign o_underrun  = r_underrun;

endmodule
